mux_nto1_pipe: RTL and testbench

- Parametrised successor to the fixed 32-bit 3:1 forwarding/writeback mux.
- Selects one of N WIDTH-bit inputs and carries the result through a STAGES-deep registered pipeline with valid, stall and flush control.
- Defines the output for out-of-range selects and reports them with a sticky error flag and a counter.
- Sits on the EX/MEM forwarding and writeback paths, so the datapath can retime muxes into pipeline registers without adding hazard logic.

---
 rtl/mux_pkg.sv | 15 +
 rtl/mux_pipe_stage.sv | 54 +++++
 rtl/mux_nto1_pipe.sv | 104 ++++++++++
 tb/tb_mux_nto1_pipe.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared limits and helpers for the pipelined N:1 select mux.
package mux_pkg;

  localparam int MUX_MAX_N      = 16;
  localparam int MUX_MAX_STAGES = 4;

  // Smallest select width able to index n inputs, never below 1.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/mux_pipe_stage.sv
// One pipeline register: data/err load only on an incoming valid beat,
// valid clears on flush, everything freezes on stall.
module mux_pipe_stage #(
  parameter int W = 32
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         flush,
  input  logic         stall,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_err,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_err
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         err_q, err_d;

  always_comb begin
    data_d  = data_q;
    err_d   = err_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d = in_valid;
      // Payload only moves with a valid beat to keep idle toggling down.
      if (in_valid) begin
        data_d = in_data;
        err_d  = in_err;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_err   = err_q;

endmodule

// File: rtl/mux_nto1_pipe.sv
// N:1 select mux followed by a STAGES-deep valid/stall/flush pipeline,
// with sticky out-of-range flag and saturating error counter.
module mux_nto1_pipe
  import mux_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int N      = 3,
  parameter int SEL_W  = clog2_min1(N),
  parameter int STAGES = 1,
  parameter int CNT_W  = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [N*WIDTH-1:0] in_flat,
  input  logic [SEL_W-1:0]   sel,
  input  logic               in_valid,
  input  logic               stall,
  input  logic               flush,
  output logic [WIDTH-1:0]   out,
  output logic               out_valid,
  output logic               out_err,
  output logic               sel_err,
  output logic [CNT_W-1:0]   err_count
);

  if (N < 2 || N > MUX_MAX_N) begin : g_bad_n
    $error("mux_nto1_pipe: N=%0d outside 2..%0d", N, MUX_MAX_N);
  end
  if ((1 << SEL_W) < N) begin : g_bad_sel_w
    $error("mux_nto1_pipe: SEL_W=%0d cannot index N=%0d inputs", SEL_W, N);
  end
  if (STAGES < 1 || STAGES > MUX_MAX_STAGES) begin : g_bad_stages
    $error("mux_nto1_pipe: STAGES=%0d outside 1..%0d", STAGES, MUX_MAX_STAGES);
  end

  logic [WIDTH-1:0] dec_data;
  logic             dec_err;

  // Out-of-range selects resolve to zero data with err set, never a held value.
  always_comb begin
    dec_data = '0;
    dec_err  = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (int'(sel) == k) begin
        dec_data = in_flat[k*WIDTH +: WIDTH];
        dec_err  = 1'b0;
      end
    end
  end

  logic [STAGES:0][WIDTH-1:0] st_data;
  logic [STAGES:0]            st_valid;
  logic [STAGES:0]            st_err;

  assign st_data[0]  = dec_data;
  assign st_valid[0] = in_valid;
  assign st_err[0]   = dec_err;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    mux_pipe_stage #(.W(WIDTH)) u_stage (
      .Clk       (Clk),
      .Reset     (Reset),
      .flush     (flush),
      .stall     (stall),
      .in_valid  (st_valid[gi]),
      .in_data   (st_data[gi]),
      .in_err    (st_err[gi]),
      .out_valid (st_valid[gi+1]),
      .out_data  (st_data[gi+1]),
      .out_err   (st_err[gi+1])
    );
  end

  assign out       = st_data[STAGES];
  assign out_valid = st_valid[STAGES];
  assign out_err   = st_err[STAGES];

  logic             bad_beat;
  logic             sel_err_q, sel_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Only beats that actually enter stage 1 are counted.
  assign bad_beat = in_valid & ~stall & ~flush & dec_err;

  always_comb begin
    sel_err_d = sel_err_q | bad_beat;
    cnt_d     = cnt_q;
    if (bad_beat && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sel_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sel_err_q <= sel_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign sel_err   = sel_err_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Scoreboard bench: three instances (STAGES=1,2,3) share one directed stimulus stream.
module tb_mux_nto1_pipe;

  localparam logic [31:0] VA = 32'h1111_1111;
  localparam logic [31:0] VB = 32'h2222_2222;
  localparam logic [31:0] VC = 32'h3333_3333;

  logic        Clk = 1'b0;
  logic        Reset, in_valid, stall, flush;
  logic [95:0] in_flat;
  logic [1:0]  sel;
  logic [31:0] exp_d;
  logic        exp_e;
  logic        done = 1'b0;

  logic [31:0] o_data [3];
  logic        o_valid [3];
  logic        o_err [3];
  logic        o_serr [3];
  logic [7:0]  o_cnt [3];
  logic [3:0]  cnt0;
  logic [7:0]  cnt1, cnt2;

  assign o_cnt[0] = {4'b0, cnt0};
  assign o_cnt[1] = cnt1;
  assign o_cnt[2] = cnt2;

  always #5 Clk = ~Clk;

  mux_nto1_pipe #(.WIDTH(32), .N(3), .SEL_W(2), .STAGES(1), .CNT_W(4)) u_dut0 (
    .Clk(Clk), .Reset(Reset), .in_flat(in_flat), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out(o_data[0]), .out_valid(o_valid[0]),
    .out_err(o_err[0]), .sel_err(o_serr[0]), .err_count(cnt0));
  mux_nto1_pipe #(.WIDTH(32), .N(3), .SEL_W(2), .STAGES(2), .CNT_W(8)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .in_flat(in_flat), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out(o_data[1]), .out_valid(o_valid[1]),
    .out_err(o_err[1]), .sel_err(o_serr[1]), .err_count(cnt1));
  mux_nto1_pipe #(.WIDTH(32), .N(3), .SEL_W(2), .STAGES(3), .CNT_W(8)) u_dut2 (
    .Clk(Clk), .Reset(Reset), .in_flat(in_flat), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out(o_data[2]), .out_valid(o_valid[2]),
    .out_err(o_err[2]), .sel_err(o_serr[2]), .err_count(cnt2));

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    int          adv;
  } exp_t;

  typedef enum int {K_NONE, K_RST, K_FLUSH, K_STALL, K_ADV} kind_e;

  exp_t  exp_q [3][$];
  kind_e kind = K_NONE;
  int    adv = 0;
  logic  acc = 1'b0;
  logic [31:0] pend_d = '0;
  logic        pend_e = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;
  int m_cnt [3] = '{0, 0, 0};
  logic m_serr [3] = '{1'b0, 1'b0, 1'b0};
  int cnt_max [3] = '{15, 255, 255};
  logic [31:0] p_data [3];
  logic        p_valid [3];
  logic        p_err [3];
  exp_t        e;

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h, required %0h", nm, d, act, want);
    end
  endtask

  // Classify each edge from the inputs held across it.
  always @(posedge Clk) begin
    acc <= 1'b0;
    if (Reset) kind <= K_RST;
    else if (flush) kind <= K_FLUSH;
    else if (stall) kind <= K_STALL;
    else begin
      kind   <= K_ADV;
      adv    <= adv + 1;
      acc    <= in_valid;
      pend_d <= exp_d;
      pend_e <= exp_e;
    end
  end

  always @(negedge Clk) begin
    for (int d = 0; d < 3; d++) begin
      case (kind)
        K_RST: begin
          exp_q[d].delete();
          m_cnt[d]  = 0;
          m_serr[d] = 1'b0;
          chk("rst_out", d, 64'(o_data[d]), 64'(0));
          chk("rst_valid", d, 64'(o_valid[d]), 64'(0));
          chk("rst_err", d, 64'(o_err[d]), 64'(0));
        end
        K_FLUSH: begin
          exp_q[d].delete();
          chk("flush_valid", d, 64'(o_valid[d]), 64'(0));
        end
        K_STALL: begin
          chk("stall_out", d, 64'(o_data[d]), 64'(p_data[d]));
          chk("stall_valid", d, 64'(o_valid[d]), 64'(p_valid[d]));
          chk("stall_err", d, 64'(o_err[d]), 64'(p_err[d]));
        end
        K_ADV: begin
          if (acc) begin
            exp_q[d].push_back('{data: pend_d, err: pend_e, adv: adv});
            if (pend_e) begin
              m_serr[d] = 1'b1;
              if (m_cnt[d] < cnt_max[d]) m_cnt[d]++;
            end
          end
          if (o_valid[d]) begin
            if (exp_q[d].size() == 0) begin
              chk("unexpected_beat", d, 64'(o_data[d]), 64'(0) - 64'(1));
            end else begin
              e = exp_q[d].pop_front();
              $display("dut%0d beat out=%h err=%0b (want %h/%0b)", d, o_data[d], o_err[d], e.data, e.err);
              chk("beat_data", d, 64'(o_data[d]), 64'(e.data));
              chk("beat_err", d, 64'(o_err[d]), 64'(e.err));
              chk("beat_latency", d, 64'(adv), 64'(e.adv + d));
            end
          end
        end
        default: ;
      endcase
      if (kind != K_NONE) begin
        chk("sel_err", d, 64'(o_serr[d]), 64'(m_serr[d]));
        chk("err_count", d, 64'(o_cnt[d]), 64'(m_cnt[d]));
      end
      p_data[d]  = o_data[d];
      p_valid[d] = o_valid[d];
      p_err[d]   = o_err[d];
    end
    if (done) begin
      for (int d = 0; d < 3; d++) chk("lost_beats", d, 64'(exp_q[d].size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
    end
  end

  task automatic cyc(input logic [1:0] s, input logic v, input logic st, input logic fl,
                     input logic rs, input logic [31:0] ed, input logic ee);
    sel = s; in_valid = v; stall = st; flush = fl; Reset = rs; exp_d = ed; exp_e = ee;
    @(posedge Clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] s, input logic [31:0] ed, input logic ee);
    cyc(s, 1'b1, 1'b0, 1'b0, 1'b0, ed, ee);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    in_flat = {VC, VB, VA};
    sel = 2'd0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; Reset = 1'b1;
    exp_d = '0; exp_e = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    // Order and latency
    beat(2'd0, VA, 1'b0); beat(2'd1, VB, 1'b0); beat(2'd2, VC, 1'b0);
    idle(4);
    // Out-of-range select, then a legal one
    beat(2'd3, 32'h0, 1'b1); beat(2'd0, VA, 1'b0);
    idle(4);
    // Stall with beats in flight; beats offered during stall are dropped
    beat(2'd0, VA, 1'b0); beat(2'd1, VB, 1'b0); beat(2'd2, VC, 1'b0); beat(2'd0, VA, 1'b0);
    cyc(2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    idle(5);
    // Flush together with stall, carrying an out-of-range beat
    beat(2'd1, VB, 1'b0); beat(2'd2, VC, 1'b0);
    cyc(2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    idle(4);
    // Counter saturation, then reset
    repeat (20) beat(2'd3, 32'h0, 1'b1);
    idle(4);
    cyc(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    idle(2);
    // Reset while beats are in flight
    beat(2'd1, VB, 1'b0); beat(2'd2, VC, 1'b0);
    cyc(2'd0, 1'b1, 1'b0, 1'b0, 1'b1, VA, 1'b0);
    beat(2'd0, VA, 1'b0);
    idle(5);
    done = 1'b1;
  end

endmodule
